// File: rtl/psevdo_ram_pkg.sv
// Shared constants and types for the psevdo_ram initiator blocks: word and
// address widths, RAM depth, output buffer depth and the read-issue test.
package psevdo_ram_pkg;

    localparam int DW         = 9;
    localparam int AW         = 8;
    localparam int DEPTH      = 1 << AW;
    localparam int OBUF_DEPTH = 3;

    typedef logic [DW-1:0] word_t;
    typedef logic [AW-1:0] addr_t;
    typedef logic [AW:0]   cnt_t;    // 0..DEPTH (and LEVEL up to DEPTH+OBUF_DEPTH)
    typedef logic [1:0]    ocnt_t;   // output buffer occupancy, 0..OBUF_DEPTH
    typedef logic [1:0]    optr_t;   // output buffer slot index

    localparam cnt_t DEPTH_CNT = cnt_t'(DEPTH);

    // A new read may be issued only if, after this cycle's pop, the words
    // already in the buffer plus the reads still travelling through the RAM
    // leave a free slot for it. This is what keeps the buffer from overflowing.
    function automatic logic obuf_has_room(input ocnt_t      obuf_cnt,
                                           input logic [1:0] pend,
                                           input logic       pop);
        logic [2:0] occ;
        occ = 3'(obuf_cnt) + 3'(pend) - 3'(pop);
        return occ <= 3'(OBUF_DEPTH - 1);
    endfunction

endpackage

// File: rtl/psevdo_ram_obuf.sv
// Small synchronous FIFO that catches RAM read data and presents the head
// word to a consumer. A write and a pop in the same cycle are both honoured.
module psevdo_ram_obuf
    import psevdo_ram_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  push_i,
    input  word_t push_data_i,
    input  logic  pop_i,
    output word_t head_o,
    output ocnt_t count_o
);

    word_t mem_q [OBUF_DEPTH];
    word_t mem_d [OBUF_DEPTH];
    optr_t wr_ptr_q, wr_ptr_d;
    optr_t rd_ptr_q, rd_ptr_d;
    ocnt_t cnt_q, cnt_d;
    logic  full, empty;
    logic  do_push, do_pop;

    // Slot index wraps after the last entry (the depth is not a power of two).
    function automatic optr_t ptr_inc(input optr_t p);
        return (p == optr_t'(OBUF_DEPTH - 1)) ? '0 : p + optr_t'(1);
    endfunction

    assign full    = (cnt_q == ocnt_t'(OBUF_DEPTH));
    assign empty   = (cnt_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = cnt_q;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_pop   = pop_i & ~empty;
        do_push  = push_i & (~full | do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        cnt_d = cnt_q + ocnt_t'(do_push) - ocnt_t'(do_pop);
    end

    // Buffer registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: flops are assigned with <= so every register samples pre-edge values.
        if (rst) begin
            // NOTE: only three entries, so they are cleared to give a defined head word after reset; the large RAM is never cleared.
            for (int i = 0; i < OBUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/psevdo_ram_fifo_ctrl.sv
// FIFO controller on the initiator side of a psevdo_ram_block port pair.
// Input stream words are written to the RAM, read back in order two cycles
// later, caught in a 3-entry buffer and offered as the output stream.
// All RAM command signals are registered; RAM_DO1 arrives the cycle after the
// RAM samples a low RDB.
module psevdo_ram_fifo_ctrl
    import psevdo_ram_pkg::*;
(
    input  logic          CLKS,
    input  logic          RST,
    input  logic [DW-1:0] IN_DATA,
    input  logic          IN_VALID,
    output logic          IN_READY,
    output logic [DW-1:0] OUT_DATA,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [AW:0]   LEVEL,
    output logic          FULL,
    output logic          EMPTY,
    output logic [DW-1:0] RAM_DIN,
    output logic [AW-1:0] RAM_WADDR,
    output logic          RAM_WRB,
    output logic [AW-1:0] RAM_RADDR,
    output logic          RAM_RDB,
    input  logic [DW-1:0] RAM_DO1
);

    // RAM pointers and bookkeeping
    addr_t      wr_ptr_q, wr_ptr_d;
    addr_t      rd_ptr_q, rd_ptr_d;
    cnt_t       ram_cnt_q, ram_cnt_d;   // written but not yet read from RAM
    cnt_t       level_q, level_d;       // everything held: RAM + in flight + buffer
    logic [1:0] rd_vld_q, rd_vld_d;     // [0] command registered, [1] RAM sampled

    // Registered RAM command port
    word_t      ram_din_q, ram_din_d;
    addr_t      ram_waddr_q, ram_waddr_d;
    logic       ram_wrb_q, ram_wrb_d;
    addr_t      ram_raddr_q, ram_raddr_d;
    logic       ram_rdb_q, ram_rdb_d;

    logic       push, pop, issue, land;
    logic [1:0] pend;
    word_t      obuf_head;
    ocnt_t      obuf_cnt;

    assign FULL      = (ram_cnt_q == DEPTH_CNT);
    assign IN_READY  = ~FULL;
    assign OUT_VALID = (obuf_cnt != '0);
    assign OUT_DATA  = obuf_head;
    assign LEVEL     = level_q;
    assign EMPTY     = (level_q == '0);

    assign RAM_DIN   = ram_din_q;
    assign RAM_WADDR = ram_waddr_q;
    assign RAM_WRB   = ram_wrb_q;
    assign RAM_RADDR = ram_raddr_q;
    assign RAM_RDB   = ram_rdb_q;

    assign push = IN_VALID & IN_READY;
    assign pop  = OUT_VALID & OUT_READY;
    assign pend = {1'b0, rd_vld_q[0]} + {1'b0, rd_vld_q[1]};
    assign land = rd_vld_q[1];   // RAM_DO1 carries a requested word this cycle

    // Registered ram_cnt means a word pushed this cycle is read no earlier
    // than next cycle, so the read command always trails its write command.
    assign issue = (ram_cnt_q != '0) & obuf_has_room(obuf_cnt, pend, pop);

    psevdo_ram_obuf u_obuf (
        .clk         (CLKS),
        .rst         (RST),
        .push_i      (land),
        .push_data_i (RAM_DO1),
        .pop_i       (pop),
        .head_o      (obuf_head),
        .count_o     (obuf_cnt)
    );

    // Next-state for pointers, counters, read pipeline and RAM commands.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ram_din_d   = ram_din_q;
        ram_waddr_d = ram_waddr_q;
        ram_wrb_d   = 1'b1;
        ram_raddr_d = ram_raddr_q;
        ram_rdb_d   = 1'b1;

        if (push) begin
            ram_din_d   = IN_DATA;
            ram_waddr_d = wr_ptr_q;
            ram_wrb_d   = 1'b0;
            wr_ptr_d    = wr_ptr_q + addr_t'(1);
        end

        if (issue) begin
            ram_raddr_d = rd_ptr_q;
            ram_rdb_d   = 1'b0;
            rd_ptr_d    = rd_ptr_q + addr_t'(1);
        end

        ram_cnt_d = ram_cnt_q + cnt_t'(push) - cnt_t'(issue);
        rd_vld_d  = {rd_vld_q[0], issue};
        // Issue and landing only move words between stages; the total
        // changes only at the stream boundaries.
        level_d   = level_q + cnt_t'(push) - cnt_t'(pop);
    end

    // Controller registers with synchronous reset; in-flight reads are dropped.
    always_ff @(posedge CLKS) begin
        if (RST) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ram_cnt_q   <= '0;
            level_q     <= '0;
            rd_vld_q    <= '0;
            ram_din_q   <= '0;
            ram_waddr_q <= '0;
            ram_wrb_q   <= 1'b1;
            ram_raddr_q <= '0;
            ram_rdb_q   <= 1'b1;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_cnt_q   <= ram_cnt_d;
            level_q     <= level_d;
            rd_vld_q    <= rd_vld_d;
            ram_din_q   <= ram_din_d;
            ram_waddr_q <= ram_waddr_d;
            ram_wrb_q   <= ram_wrb_d;
            ram_raddr_q <= ram_raddr_d;
            ram_rdb_q   <= ram_rdb_d;
        end
    end

endmodule

// File: tb/tb_psevdo_ram_fifo_ctrl.sv
// Directed and random bench for psevdo_ram_fifo_ctrl with a behavioural
// two-port RAM. Accepted input words go into a scoreboard queue; every
// accepted output word is compared against the queue head.
module tb_psevdo_ram_fifo_ctrl;
    import psevdo_ram_pkg::*;

    logic          CLKS = 1'b0;
    logic          RST;
    logic [DW-1:0] IN_DATA;
    logic          IN_VALID;
    logic          IN_READY;
    logic [DW-1:0] OUT_DATA;
    logic          OUT_VALID;
    logic          OUT_READY;
    logic [AW:0]   LEVEL;
    logic          FULL;
    logic          EMPTY;
    logic [DW-1:0] RAM_DIN;
    logic [AW-1:0] RAM_WADDR;
    logic          RAM_WRB;
    logic [AW-1:0] RAM_RADDR;
    logic          RAM_RDB;
    logic [DW-1:0] RAM_DO1;

    always #5 CLKS = ~CLKS;

    psevdo_ram_fifo_ctrl dut (
        .CLKS      (CLKS),
        .RST       (RST),
        .IN_DATA   (IN_DATA),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .OUT_DATA  (OUT_DATA),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .LEVEL     (LEVEL),
        .FULL      (FULL),
        .EMPTY     (EMPTY),
        .RAM_DIN   (RAM_DIN),
        .RAM_WADDR (RAM_WADDR),
        .RAM_WRB   (RAM_WRB),
        .RAM_RADDR (RAM_RADDR),
        .RAM_RDB   (RAM_RDB),
        .RAM_DO1   (RAM_DO1)
    );

    // Behavioural RAM: both ports on CLKS, write and read sampled at posedge.
    word_t ram_mem [DEPTH];
    always @(posedge CLKS) begin
        if (!RAM_WRB) ram_mem[RAM_WADDR] <= RAM_DIN;
        if (!RAM_RDB) RAM_DO1 <= ram_mem[RAM_RADDR];
    end

    int    checks   = 0;
    int    failures = 0;
    word_t sb [$];
    int    lvl_m    = 0;
    logic  last_push, last_pop;

    int sent, cyc, t, snd, rcv, first_out, last_out, wr0, rd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Book one cycle: decide handshakes from stable pre-edge values, update
    // the scoreboard and level model, then advance to the next negedge.
    task automatic tick();
        logic  push_acc, pop_acc;
        word_t exp;
        push_acc = (RST === 1'b0) && (IN_VALID === 1'b1) && (IN_READY === 1'b1);
        pop_acc  = (RST === 1'b0) && (OUT_VALID === 1'b1) && (OUT_READY === 1'b1);
        if (RST === 1'b0)
            check("obuf_no_overflow",
                  32'(dut.land && (dut.obuf_cnt == 2'd3) && !pop_acc), 32'd0);
        if (pop_acc) begin
            check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                check("sb_data", 32'(OUT_DATA), 32'(exp));
            end
        end
        if (push_acc) sb.push_back(IN_DATA);
        lvl_m     = lvl_m + int'(push_acc) - int'(pop_acc);
        last_push = push_acc;
        last_pop  = pop_acc;
        @(negedge CLKS);
    endtask

    task automatic drain(input string tag);
        int n;
        n         = 0;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        while (lvl_m != 0 && n < 1000) begin
            tick();
            n++;
        end
        check({tag, "_drained"}, 32'(lvl_m), 32'd0);
        check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
        check({tag, "_EMPTY"}, 32'(EMPTY), 32'd1);
        OUT_READY = 1'b0;
    endtask

    initial begin
        // 1. Reset
        RST = 1'b1; IN_VALID = 1'b0; IN_DATA = '0; OUT_READY = 1'b0;
        repeat (2) tick();
        RST = 1'b0;
        check("rst_WRB", 32'(RAM_WRB), 32'd1);
        check("rst_RDB", 32'(RAM_RDB), 32'd1);
        check("rst_WADDR", 32'(RAM_WADDR), 32'd0);
        check("rst_RADDR", 32'(RAM_RADDR), 32'd0);
        check("rst_DIN", 32'(RAM_DIN), 32'd0);
        check("rst_EMPTY", 32'(EMPTY), 32'd1);
        check("rst_FULL", 32'(FULL), 32'd0);
        check("rst_LEVEL", 32'(LEVEL), 32'd0);
        check("rst_OUT_VALID", 32'(OUT_VALID), 32'd0);
        check("rst_OUT_DATA", 32'(OUT_DATA), 32'd0);
        check("rst_IN_READY", 32'(IN_READY), 32'd1);

        // 2. Single word latency
        IN_VALID = 1'b1; IN_DATA = 9'h1A5; OUT_READY = 1'b1;
        tick();                                   // now c1
        IN_VALID = 1'b0;
        check("c1_WRB", 32'(RAM_WRB), 32'd0);
        check("c1_WADDR", 32'(RAM_WADDR), 32'd0);
        check("c1_DIN", 32'(RAM_DIN), 32'h1A5);
        check("c1_LEVEL", 32'(LEVEL), 32'd1);
        tick();                                   // c2
        check("c2_RDB", 32'(RAM_RDB), 32'd0);
        check("c2_RADDR", 32'(RAM_RADDR), 32'd0);
        check("c2_WRB", 32'(RAM_WRB), 32'd1);
        tick();                                   // c3
        check("c3_OUT_VALID", 32'(OUT_VALID), 32'd0);
        tick();                                   // c4
        check("c4_OUT_VALID", 32'(OUT_VALID), 32'd1);
        check("c4_OUT_DATA", 32'(OUT_DATA), 32'h1A5);
        tick();                                   // c5, word popped
        check("c5_EMPTY", 32'(EMPTY), 32'd1);
        check("c5_OUT_VALID", 32'(OUT_VALID), 32'd0);

        // 3. Fill to 259 with the consumer stalled
        OUT_READY = 1'b0; sent = 0; cyc = 0;
        while (sent < 259 && cyc < 400) begin
            IN_VALID = 1'b1;
            IN_DATA  = word_t'(sent);
            tick();
            if (last_push) sent++;
            cyc++;
        end
        IN_VALID = 1'b0;
        check("fill_accepted", 32'(sent), 32'd259);
        check("fill_no_stall", 32'(cyc), 32'd259);
        check("fill_FULL", 32'(FULL), 32'd1);
        check("fill_IN_READY", 32'(IN_READY), 32'd0);
        check("fill_LEVEL", 32'(LEVEL), 32'd259);
        IN_VALID = 1'b1; IN_DATA = 9'h1FF;
        tick();
        IN_VALID = 1'b0;
        check("full_push_blocked", 32'(last_push), 32'd0);
        check("full_LEVEL_held", 32'(LEVEL), 32'd259);
        check("full_head_valid", 32'(OUT_VALID), 32'd1);
        check("full_head_data", 32'(OUT_DATA), 32'd0);
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
        check("pop_from_full", 32'(last_pop), 32'd1);
        check("unfull_FULL", 32'(FULL), 32'd0);
        check("unfull_IN_READY", 32'(IN_READY), 32'd1);
        check("unfull_LEVEL", 32'(LEVEL), 32'd258);
        drain("fill");

        // 4. Streaming 600 words with both address pointers wrapping twice
        t = 0; snd = 0; rcv = 0; first_out = -1; last_out = -1; wr0 = 0; rd0 = 0;
        while (rcv < 600 && t < 800) begin
            IN_VALID = (snd < 600);
            IN_DATA  = word_t'(snd * 7 + 3);
            OUT_READY = 1'b1;
            if (RAM_WRB === 1'b0 && RAM_WADDR === '0) wr0++;
            if (RAM_RDB === 1'b0 && RAM_RADDR === '0) rd0++;
            if (OUT_VALID === 1'b1) begin
                if (first_out < 0) first_out = t;
                last_out = t;
            end
            tick();
            if (last_push) snd++;
            if (last_pop) rcv++;
            t++;
        end
        IN_VALID = 1'b0;
        check("stream_received", 32'(rcv), 32'd600);
        check("stream_latency", 32'(first_out), 32'd4);
        check("stream_no_gaps", 32'(last_out - first_out), 32'd599);
        check("stream_waddr_wraps", 32'(wr0), 32'd2);
        check("stream_raddr_wraps", 32'(rd0), 32'd2);
        drain("stream");

        // 5. Random valid/ready on both sides
        for (int i = 0; i < 5000; i++) begin
            IN_VALID  = 1'($urandom_range(0, 1));
            IN_DATA   = word_t'($urandom);
            OUT_READY = 1'($urandom_range(0, 1));
            check("rand_LEVEL", 32'(LEVEL), 32'(lvl_m));
            tick();
        end
        drain("rand");

        // 6. Reset with words stored and reads in flight
        OUT_READY = 1'b0;
        for (int i = 0; i < 10; i++) begin
            IN_VALID = 1'b1;
            IN_DATA  = word_t'(9'h100 + i);
            tick();
        end
        IN_VALID = 1'b0; OUT_READY = 1'b1;
        tick();                                   // pop frees a slot, read issued
        OUT_READY = 1'b0; RST = 1'b1;
        tick();
        RST = 1'b0;
        sb.delete();
        lvl_m = 0;
        check("mrst_LEVEL", 32'(LEVEL), 32'd0);
        check("mrst_OUT_VALID", 32'(OUT_VALID), 32'd0);
        check("mrst_EMPTY", 32'(EMPTY), 32'd1);
        repeat (3) tick();
        check("mrst_stale_ignored", 32'(OUT_VALID), 32'd0);
        IN_VALID = 1'b1; IN_DATA = 9'h055; OUT_READY = 1'b1;
        tick();
        IN_VALID = 1'b0;
        check("mrst_WADDR", 32'(RAM_WADDR), 32'd0);
        check("mrst_WRB", 32'(RAM_WRB), 32'd0);
        tick();
        check("mrst_RADDR", 32'(RAM_RADDR), 32'd0);
        check("mrst_RDB", 32'(RAM_RDB), 32'd0);
        cyc = 0;
        while (OUT_VALID !== 1'b1 && cyc < 10) begin
            tick();
            cyc++;
        end
        check("mrst_first_valid", 32'(OUT_VALID), 32'd1);
        check("mrst_first_data", 32'(OUT_DATA), 32'h055);
        tick();
        drain("mrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/psevdo_ram_fifo_ctrl.md
Name: psevdo_ram_fifo_ctrl

Overview:
- Single-clock FIFO controller that is the initiator side of the psevdo_ram_block port pair.
- Accepts a 9-bit valid/ready input stream and drives the RAM write port (RAM_DIN/RAM_WADDR/RAM_WRB).
- Drives the RAM read port (RAM_RADDR/RAM_RDB), collects RAM_DO1 into a small output buffer and presents it as a valid/ready output stream.
- At top level, WCLKS and RCLKS of the RAM are both tied to CLKS. DO2 is not used.

Parameters:
DW, 9, data width; equals RAM word width.
AW, 8, RAM address width; DEPTH = 2**AW = 256 words.
OBUF_DEPTH, 3, output buffer entries; fixed at 3, minimum needed for full read throughput.

Ports:
CLKS  in  1  clock; all logic rises on posedge.
RST  in  1  synchronous, active-high reset.
IN_DATA  in  DW  write data.
IN_VALID  in  1  write request.
IN_READY  out  1  = !FULL.
OUT_DATA  out  DW  head-of-FIFO word; valid when OUT_VALID.
OUT_VALID  out  1  output buffer non-empty.
OUT_READY  in  1  consumer accepts OUT_DATA.
LEVEL  out  AW+1  total words held (RAM + in flight + buffer), 0..259.
FULL  out  1  RAM holds DEPTH unread words.
EMPTY  out  1  LEVEL==0.
RAM_DIN  out  DW  to RAM DIn, registered.
RAM_WADDR  out  AW  to RAM WADDR, registered.
RAM_WRB  out  1  to RAM WRB; active-low, registered.
RAM_RADDR  out  AW  to RAM RADDR, registered.
RAM_RDB  out  1  to RAM RDB; active-low, registered.
RAM_DO1  in  DW  from RAM DO1; valid in the cycle after the RAM samples RDB low.

Behaviour:
- Reset (RST=1 at posedge) sets: wr_ptr=rd_ptr=0, ram_cnt=0, pend=0, obuf empty.
- Output values after reset: RAM_WRB=1, RAM_RDB=1, RAM_WADDR=RAM_RADDR=0, RAM_DIN=0, OUT_VALID=0, OUT_DATA=0, LEVEL=0, FULL=0, EMPTY=1, IN_READY=1.
- RAM contents are not cleared by reset. Reads in flight at reset are discarded, and RAM_DO1 is ignored until a new read is issued.
- push = IN_VALID & IN_READY.
  - On push: RAM_DIN<=IN_DATA, RAM_WADDR<=wr_ptr, RAM_WRB<=0, wr_ptr++ (wraps 255->0).
  - Otherwise RAM_WRB<=1.
  - The RAM stores the word on the following edge.
- ram_cnt (AW+1 bits) = words written but not yet read from RAM. FULL = (ram_cnt==DEPTH).
- issue = (ram_cnt!=0) & (obuf_cnt + pend - pop <= OBUF_DEPTH-1), where pop = OUT_VALID & OUT_READY.
  - The condition uses registered ram_cnt, so a word pushed this cycle is not readable until the next cycle.
  - Read-after-write safety: the read command is registered at least one edge after the write command.
- On issue: RAM_RADDR<=rd_ptr, RAM_RDB<=0, rd_ptr++ (wraps). Otherwise RAM_RDB<=1.
- pend (0..2) tracks issued reads across two pipeline stages:
  - stage 1: command register;
  - stage 2: RAM sample.
  - A 2-bit valid shift register tracks them; in the cycle after stage 2, RAM_DO1 is written into obuf.
- ram_cnt update: +push −issue. Simultaneous push and issue leaves it unchanged. At FULL no push is possible.
- obuf is a 3-entry FIFO.
  - Writes come from the RAM_DO1 landing; reads are pops.
  - OUT_DATA = head entry.
  - A landing and a pop in the same cycle are both honoured.
  - The issue rule guarantees obuf never overflows; the bench asserts this.
- Latency and throughput:
  - A word pushed in cycle c0 into an empty FIFO gives OUT_VALID=1 in cycle c4.
  - Sustained rate is 1 word/cycle in and out.
- LEVEL = ram_cnt + pend + obuf_cnt, registered, consistent with the other outputs in the same cycle.
- Ordering: strict FIFO. No word is lost or duplicated under any OUT_READY/IN_VALID pattern.
- Boundary cases:
  - OUT_READY held 0 while filling: the controller drains 3 words into obuf, then accepts up to DEPTH more. The maximum accepted is therefore 259, after which FULL=1 and IN_READY=0.
  - FULL deasserts in the cycle after the first issue.
  - Push and pop while FULL: push is blocked by IN_READY.

Decomposition:
- Package psevdo_ram_pkg holds: DW, AW, DEPTH, OBUF_DEPTH, and the word typedef (logic [DW-1:0]).
- Sub-module psevdo_ram_obuf is the 3-entry synchronous FIFO (push, pop, head, count). It is reused by future RAM readers.
- Pointer, count and issue logic stay in the top.

Test Plan:
1. Reset: assert RST for 2 cycles -> RAM_WRB=1, RAM_RDB=1, EMPTY=1, LEVEL=0, OUT_VALID=0, IN_READY=1.
2. Single word: push 0x1A5 in c0, OUT_READY=1 ->
   - RAM_WRB=0 with RAM_WADDR=0 in c1;
   - RAM_RDB=0 with RAM_RADDR=0 in c2;
   - OUT_VALID=1 with OUT_DATA=0x1A5 in c4;
   - EMPTY=1 in c5.
3. Fill: OUT_READY=0, push the incrementing pattern 0..258 -> IN_READY=0, FULL=1, LEVEL=259 after the 259th accept. Then one pop -> OUT_DATA=0 leaves and FULL drops within 2 cycles.
4. Streaming with wrap: 600 words, IN_VALID=OUT_READY=1 -> outputs in order, one per cycle after the 4-cycle latency; RAM_WADDR and RAM_RADDR wrap 255->0 twice.
5. Backpressure: random IN_VALID and OUT_READY (50%) for 5000 cycles against a scoreboard -> no loss, duplication or reorder; obuf is never written while full; LEVEL matches the model every cycle.
6. Reset mid-operation: with 10 words stored and reads in flight, pulse RST -> LEVEL=0 and OUT_VALID=0 next cycle. Then push 0x055 -> the first output is 0x055, read from RAM_RADDR=0.
